// File: rtl/rf_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rf_exec_sequencer
// Purpose  : Execute/writeback stage that owns the register file control pins.
//            Optional iterative multiply enabled by macro RF_EXEC_MUL_EN.
// Revision : 1.0  initial release
// ============================================================================
module rf_exec_sequencer #(
  parameter int DW         = 32,
  parameter int SW         = 8,
  parameter int MUL_CYCLES = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [SW-1:0] in_rs1,
  input  logic [SW-1:0] in_rs2,
  input  logic [SW-1:0] in_rd,
  input  logic [DW-1:0] in_imm,
  input  logic          in_use_imm,
  output logic          rf_en,
  output logic          rf_read,
  output logic          rf_write,
  output logic [SW-1:0] rf_selR1,
  output logic [SW-1:0] rf_selR2,
  output logic [SW-1:0] rf_selW,
  output logic [DW-1:0] rf_wdata,
  input  logic [DW-1:0] rf_outA,
  input  logic [DW-1:0] rf_outB,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  localparam int SHW = $clog2(DW);

  logic [2:0]    state, state_nx;
  logic [3:0]    op;
  logic [SW-1:0] rd;
  logic [DW-1:0] imm;
  logic          use_imm;
  logic [DW-1:0] opa, opb;
  logic          is_mul, legal, exec_last;
  logic [DW-1:0] alu;

  logic          en_d, read_d, write_d, done_d, err_d;
  logic [SW-1:0] sel_r1_d, sel_r2_d, sel_w_d;
  logic [DW-1:0] result_d;

  assign in_ready = (state == S_IDLE);
  assign legal    = (op <= OP_SRA) || is_mul;
  assign rf_wdata = result;

`ifdef RF_EXEC_MUL_EN
  localparam int CW = $clog2(MUL_CYCLES + 1);
  logic [CW-1:0] mcnt;
  logic [DW-1:0] acc, acc_nx;

  // Radix-2 shift-add: opa shifts left, opb shifts right, one bit per cycle.
  assign is_mul    = (op == OP_MUL);
  assign acc_nx    = acc + (opb[0] ? opa : '0);
  assign exec_last = !is_mul || (mcnt == CW'(MUL_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcnt <= '0;
      acc  <= '0;
    end else if (state == S_WAIT) begin
      mcnt <= '0;
      acc  <= '0;
    end else if (state == S_EXEC && is_mul) begin
      mcnt <= mcnt + 1'b1;
      acc  <= acc_nx;
    end
  end
`else
  assign is_mul    = 1'b0;
  assign exec_last = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op      <= '0;
      rd      <= '0;
      imm     <= '0;
      use_imm <= 1'b0;
      opa     <= '0;
      opb     <= '0;
    end else begin
      if (state == S_IDLE && in_valid) begin
        op      <= in_op;
        rd      <= in_rd;
        imm     <= in_imm;
        use_imm <= in_use_imm;
      end
      if (state == S_WAIT) begin
        opa <= rf_outA;
        opb <= use_imm ? imm : rf_outB;
      end
`ifdef RF_EXEC_MUL_EN
      else if (state == S_EXEC && is_mul) begin
        opa <= opa << 1;
        opb <= opb >> 1;
      end
`endif
    end
  end

  always_comb begin
    alu = '0;
    case (op)
      OP_ADD:  alu = opa + opb;
      OP_SUB:  alu = opa - opb;
      OP_AND:  alu = opa & opb;
      OP_OR:   alu = opa | opb;
      OP_XOR:  alu = opa ^ opb;
      OP_SLL:  alu = opa << opb[SHW-1:0];
      OP_SRL:  alu = opa >> opb[SHW-1:0];
      OP_SRA:  alu = DW'($signed(opa) >>> opb[SHW-1:0]);
`ifdef RF_EXEC_MUL_EN
      OP_MUL:  alu = acc_nx;
`endif
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (in_valid) state_nx = S_READ;
      S_READ:  state_nx = S_WAIT;
      S_WAIT:  state_nx = S_EXEC;
      S_EXEC:  if (exec_last) state_nx = S_WRITE;
      S_WRITE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    en_d     = 1'b0;
    read_d   = 1'b0;
    write_d  = 1'b0;
    done_d   = 1'b0;
    sel_r1_d = '0;
    sel_r2_d = '0;
    sel_w_d  = '0;
    result_d = result;
    err_d    = err;
    if (state_nx == S_READ) begin
      en_d     = 1'b1;
      read_d   = 1'b1;
      sel_r1_d = in_rs1;
      sel_r2_d = in_rs2;
    end
    if (state_nx == S_WRITE) begin
      en_d     = 1'b1;
      write_d  = (rd != '0) && legal;
      sel_w_d  = rd;
      done_d   = 1'b1;
      result_d = alu;
      err_d    = !legal;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_en    <= 1'b0;
      rf_read  <= 1'b0;
      rf_write <= 1'b0;
      rf_selR1 <= '0;
      rf_selR2 <= '0;
      rf_selW  <= '0;
      done     <= 1'b0;
      result   <= '0;
      err      <= 1'b0;
    end else begin
      rf_en    <= en_d;
      rf_read  <= read_d;
      rf_write <= write_d;
      rf_selR1 <= sel_r1_d;
      rf_selR2 <= sel_r2_d;
      rf_selW  <= sel_w_d;
      done     <= done_d;
      result   <= result_d;
      err      <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/rf_exec_sequencer.md
Name: rf_exec_sequencer

Overview:
- Execute/writeback stage sitting directly downstream of the general-purpose register file.
- Accepts one operation at a time through a valid/ready handshake and issues the two-operand read to the register file.
- Captures outA/outB, computes a 32-bit ALU result (including an optional iterative multiply), and writes the result back through the register file write port.
- Sole owner of the register file control pins once instantiated.

Parameters:
- DW, 32, datapath width; the register file addr/outA/outB width.
- SW, 8, register select width (selectW1/selectR1/selectR2).
- MUL_CYCLES, 32, EXEC cycles for the multiply; must equal DW.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  sequencer can accept an operation (IDLE state).
- in_op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 MUL, 9-15 illegal.
- in_rs1, in_rs2, in_rd  in  SW  source/destination register selects.
- in_imm  in  DW  immediate operand.
- in_use_imm  in  1  operand B = in_imm instead of rs2 data.
- rf_en, rf_read, rf_write  out  1  register file EN/read/write strobes.
- rf_selR1, rf_selR2, rf_selW  out  SW  register file selects.
- rf_wdata  out  DW  drives register file addr (write data).
- rf_outA, rf_outB  in  DW  register file read data.
- done  out  1  one-cycle completion pulse.
- result  out  DW  result, valid while done=1 and held until the next done.
- err  out  1  illegal opcode; valid with done.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all registered outputs 0 (rf_en, rf_read, rf_write, selects, rf_wdata, done, result, err); MUL counter 0. in_ready=1 once rst=1.
- in_ready = (state==IDLE), combinational from state. Accept on in_valid && in_ready at a rising edge; latch op, rs1, rs2, rd, imm, use_imm.
- FSM:
  - IDLE -> READ on accept.
  - READ (1 cycle): rf_en=1, rf_read=1, rf_selR1=rs1, rf_selR2=rs2. The register file presents data by the next cycle.
  - WAIT (1 cycle): capture opA=rf_outA and opB=(use_imm ? imm : rf_outB) at the end of the cycle.
  - EXEC: 1 cycle for ops 0-7 and illegal ops; MUL_CYCLES cycles for MUL.
  - WRITE (1 cycle): rf_en=1, rf_write=(rd!=0 && legal op), rf_selW=rd, rf_wdata=result; done=1.
  - WRITE -> IDLE.
- Latency from the accept edge: done is high in the 4th cycle for single-cycle ops and in the (3+MUL_CYCLES)th cycle for MUL. in_ready returns the following cycle. Throughput is 1 op per 5 cycles (non-MUL).
- Arithmetic:
  - All ops are mod 2^DW.
  - SUB = opA - opB (two's complement).
  - Shift amount = opB[4:0].
  - SRA sign-extends from opA[31].
  - MUL is radix-2 shift-add, low DW bits only, unsigned (equal to signed low half).
- rd==0: no write strobe is issued (r0 is hardwired zero in the register file); done and result are still produced.
- Illegal op: result=0, err=1, rf_write=0, done=1 in WRITE.
- rf_read and rf_write are never asserted in the same cycle. rf_en=0 in IDLE/WAIT/EXEC.
- in_valid is ignored outside IDLE, with no queuing. Input fields may change freely after accept.
- Reset mid-operation aborts immediately: no write and no done. Register file contents are untouched by this block.

Optional Feature:
- Macro RF_EXEC_MUL_EN.
- Defined: opcode 8 performs the iterative multiply (MUL_CYCLES EXEC cycles, counter + shift registers).
- Undefined: no multiplier hardware; opcode 8 is treated as illegal (err=1, no write, 1-cycle EXEC).

Test Plan:
1. After reset, ADD rs1=0, use_imm=1, imm=123, rd=1 -> rf_write=1, rf_selW=1, rf_wdata=123 in cycle 4 after accept; done=1, err=0. Repeat with imm=456, rd=3.
2. ADD rs1=1, rs2=3, rd=4 -> result=579; SUB rs1=1, rs2=3, rd=5 -> result=0xFFFFFEB3. rf_read=1 only in the cycle after accept.
3. MUL rs1=1, rs2=3, rd=6 (RF_EXEC_MUL_EN defined) -> result=0xDB18, done 35 cycles after accept. Same op without the macro -> err=1, no write, done at cycle 4.
4. ADD use_imm=1, imm=99, rd=0 -> done=1, result=99, rf_write stays 0; then read r0 via ADD rs1=0, rs2=0, rd=7 -> r7=0.
5. in_op=4'hF -> err=1, result=0, rf_write=0. in_valid held high during a busy op -> second op accepted only when in_ready=1, exactly once.
6. Assert rst=0 mid-MUL (EXEC cycle 10) -> all outputs 0 asynchronously, no rf_write ever pulsed, in_ready=1 after release. SRA opA=0x80000000, imm=4 -> 0xF8000000.
